muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the register file write port. It takes two source operands read from the register file plus a destination register address. It computes one of the eight M-extension operations over a fixed 34-cycle latency. It returns the 32-bit result with a one-cycle write strobe that drives the register file's `we`/`wrAddr`/`wrData` inputs directly.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and register-file write bus
// for the iterative RV32M multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  rdIn;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        we;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;

  modport master (
    output start, funct3, opA, opB, rdIn, flush,
    input  ready, busy, we, wrAddr, wrData
  );

  modport slave (
    input  start, funct3, opA, opB, rdIn, flush,
    output ready, busy, we, wrAddr, wrData
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed 34-cycle RV32M multiply/divide,
// shift-add multiply and restoring divide on magnitudes.
module muldiv_unit (
  input  logic clk,
  input  logic rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state, next;

  logic [2:0]  op;
  logic [4:0]  rd;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] rem;
  logic        neg_res;
  logic        neg_rem;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr;

  logic        accept;
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rmd;
  logic [31:0] result;

  assign accept = (state == IDLE) && bus.start
                  && !bus.flush;

  // operand signedness and magnitudes at accept
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (bus.funct3)
      3'b001: begin
        sa = bus.opA[31];
        sb = bus.opB[31];
      end
      3'b010: sa = bus.opA[31];
      3'b100, 3'b110: begin
        sa = bus.opA[31];
        sb = bus.opB[31];
      end
      default: ;
    endcase
    mag_a = sa ? -bus.opA : bus.opA;
    mag_b = sb ? -bus.opB : bus.opB;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // next state; flush overrides every transition
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (bus.start) next = CALC;
      CALC: if (cnt == 5'd0) next = FIX;
      FIX:  next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    if (bus.flush) next = IDLE;
  end

  // iteration step and sign/special-case fixup
  always_comb begin
    sum = {1'b0, acc[63:32]}
        + (acc[0] ? {1'b0, opnd} : 33'd0);
    shifted = {rem, acc[31]};
    ge = shifted >= {1'b0, opnd};
    diff = shifted[31:0] - opnd;
    prod = neg_res ? -acc : acc;
    if (opnd == 32'd0)
      quo = 32'hFFFF_FFFF;
    else
      quo = neg_res ? -acc[31:0] : acc[31:0];
    rmd = neg_rem ? -rem : rem;
    unique case (op)
      3'b000:                 result = prod[31:0];
      3'b001, 3'b010, 3'b011: result = prod[63:32];
      3'b100, 3'b101:         result = quo;
      default:                result = rmd;
    endcase
  end

  // datapath registers: latch at accept, iterate in CALC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= '0;
      rd      <= '0;
      cnt     <= '0;
      opnd    <= '0;
      acc     <= '0;
      rem     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op      <= bus.funct3;
      rd      <= bus.rdIn;
      cnt     <= 5'd31;
      rem     <= '0;
      opnd    <= bus.funct3[2] ? mag_b : mag_a;
      acc     <= {32'd0,
                  bus.funct3[2] ? mag_a : mag_b};
      neg_res <= sa ^ sb;
      neg_rem <= sa;
    end else if (state == CALC && !bus.flush) begin
      cnt <= cnt - 5'd1;
      if (op[2]) begin
        rem       <= ge ? diff : shifted[31:0];
        acc[31:0] <= {acc[30:0], ge};
      end else begin
        acc <= {sum, acc[31:1]};
      end
    end
  end

  // write port: updated only on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_data <= '0;
      wr_addr <= '0;
    end else if (state == FIX && !bus.flush) begin
      wr_data <= result;
      wr_addr <= rd;
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state != IDLE);
  assign bus.we     = (state == DONE);
  assign bus.wrData = wr_data;
  assign bus.wrAddr = wr_addr;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of
// muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(
    input logic [2:0] f,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic do_op(input string tag,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic [31:0] exp,
                       input bit poke);
    int n;
    int bcnt;
    bit seen;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.opA    = a;
    bus.opB    = b;
    bus.rdIn   = rd;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.opA    = $urandom;
    bus.opB    = $urandom;
    bus.rdIn   = 5'($urandom);
    chk({tag, ".busy0"}, bus.busy, 1);
    chk({tag, ".rdy0"}, bus.ready, 0);
    bcnt = bus.busy ? 1 : 0;
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      bus.start = poke && (n == 10);
      if (bus.busy) bcnt++;
      if (bus.we) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, ".lat"}, seen ? n : 0, 33);
    chk({tag, ".data"}, bus.wrData, exp);
    chk({tag, ".addr"}, bus.wrAddr, rd);
    chk({tag, ".busycnt"}, bcnt, 34);
    @(posedge clk);
    #1;
    chk({tag, ".we_off"}, bus.we, 0);
    chk({tag, ".rdy_end"}, bus.ready, 1);
  endtask

  task automatic watch_no_we(input string tag);
    int wcnt;
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.we) wcnt++;
    end
    chk(tag, wcnt, 0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    tests = 0;
    fails = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.opA    = '0;
    bus.opB    = '0;
    bus.rdIn   = '0;
    #1;
    chk("rst.ready", bus.ready, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.we", bus.we, 0);
    chk("rst.data", bus.wrData, 0);
    chk("rst.addr", bus.wrAddr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
          32'hFFFF_FFEB, 1'b0);
    do_op("mulh", 3'd1, 32'h8000_0000,
          32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b0);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9,
          32'hFFFF_FFFD, 1'b0);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10,
          32'hFFFF_FFFF, 1'b0);
    do_op("divu", 3'd5, 32'd100, 32'd7, 5'd11,
          32'd14, 1'b0);
    do_op("remu", 3'd7, 32'd100, 32'd7, 5'd12,
          32'd2, 1'b0);
    do_op("div0", 3'd4, 32'd5, 32'd0, 5'd13,
          32'hFFFF_FFFF, 1'b0);
    do_op("rem0", 3'd6, 32'd5, 32'd0, 5'd14,
          32'd5, 1'b0);
    do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd15,
          32'hFFFF_FFFF, 1'b0);
    do_op("divn0", 3'd4, 32'hFFFF_FFF0, 32'd0, 5'd16,
          32'hFFFF_FFFF, 1'b0);
    do_op("remn0", 3'd6, 32'hFFFF_FFF0, 32'd0, 5'd17,
          32'hFFFF_FFF0, 1'b0);
    do_op("divovf", 3'd4, 32'h8000_0000,
          32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1'b0);
    do_op("removf", 3'd6, 32'h8000_0000,
          32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
    do_op("poke", 3'd0, 32'd123, 32'd456, 5'd19,
          32'd56088, 1'b1);

    // flush at iteration 10
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.opA    = 32'd11;
    bus.opB    = 32'd13;
    bus.rdIn   = 5'd21;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush.ready", bus.ready, 1);
    chk("flush.we", bus.we, 0);
    watch_no_we("flush.nowe");
    chk("flush.data", bus.wrData, 32'd56088);
    chk("flush.addr", bus.wrAddr, 5'd19);

    // flush with start in idle
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("fs.ready", bus.ready, 1);
    chk("fs.busy", bus.busy, 0);
    watch_no_we("fs.nowe");
    do_op("divu93", 3'd5, 32'd9, 32'd3, 5'd22,
          32'd3, 1'b0);

    // async reset in the middle of a divide
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.opA    = 32'd1000;
    bus.opB    = 32'd7;
    bus.rdIn   = 5'd23;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst.ready", bus.ready, 1);
    chk("arst.busy", bus.busy, 0);
    chk("arst.we", bus.we, 0);
    chk("arst.data", bus.wrData, 0);
    chk("arst.addr", bus.wrAddr, 0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_we("arst.nowe");
    do_op("mul34", 3'd0, 32'd3, 32'd4, 5'd24,
          32'd12, 1'b0);

    // random operations against the reference
    for (int i = 0; i < 24; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), f, a, b, rd,
            ref_op(f, a, b), (i % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
